// File: rtl/ctrl_rw_sched.sv
// ctrl_rw_sched: read/write data-phase scheduler between CAS issue and the DDR data path.
// Latency: a command issued at edge k raises its strobe (registered) at edge k+d, where d is the clamped delay.
// Backpressure: none; a command arriving with every slot busy is dropped and flags sticky overflow.
//
// Ports:
//   CK_t, reset           clock (rising edge) and asynchronous active-high reset
//   cas_rdy, cas_req      CAS issued this cycle; type 00 WR, 01 RD, 10 WRA, 11 RDA
//   CL, CWL, AL           CAS latency, CAS write latency, additive latency
//   RD_PRE, WR_PRE        read / write preamble clocks subtracted from the latency
//   rd_rdy, wr_rdy        1-cycle data-phase start strobes
//   rda_rdy, wra_rdy      autoprecharge variants (only with CTRL_RW_AUTOPRE_EN, else 0)
//   rw_done               last clock of a BL/2-clock data burst
//   data_idle             no outstanding command and no burst in flight
//   full                  all DEPTH slots occupied
//   overflow, collision   sticky error flags, cleared only by reset
//
// Optional feature: define CTRL_RW_AUTOPRE_EN to keep WRA/RDA distinct and drive
// wra_rdy/rda_rdy; otherwise WRA folds into WR, RDA into RD, and types use 1 bit.

module ctrl_rw_sched #(
  parameter int DEPTH = 8,
  parameter int LAT_W = 6,
  parameter int BL    = 8
) (
  input  logic             CK_t,
  input  logic             reset,
  input  logic             cas_rdy,
  input  logic [1:0]       cas_req,
  input  logic [LAT_W-1:0] CL,
  input  logic [LAT_W-1:0] CWL,
  input  logic [LAT_W-1:0] AL,
  input  logic [LAT_W-1:0] RD_PRE,
  input  logic [LAT_W-1:0] WR_PRE,
  output logic             rd_rdy,
  output logic             wr_rdy,
  output logic             rda_rdy,
  output logic             wra_rdy,
  output logic             rw_done,
  output logic             data_idle,
  output logic             full,
  output logic             overflow,
  output logic             collision
);

  localparam int BST_W = $clog2(BL/2 + 1);
  localparam logic [BST_W-1:0] BST_LEN = BST_W'(BL/2);

`ifdef CTRL_RW_AUTOPRE_EN
  localparam int TYP_W = 2;
`else
  localparam int TYP_W = 1;
`endif

  // Slot storage
  logic [DEPTH-1:0] slot_vld;
  logic [LAT_W-1:0] slot_cnt  [DEPTH];
  logic [TYP_W-1:0] slot_type [DEPTH];
  logic [BST_W-1:0] burst_cnt;

  // ---------------------------------------------------------------------------
  // Delay calculation. Two extra bits keep CL+AL-PRE exact: bit LAT_W+1 is the
  // sign, and bit LAT_W set on a non-negative value means beyond the counter range.
  // The slot stores d-1 so that the release edge lands exactly on k+d.
  // ---------------------------------------------------------------------------
  logic [LAT_W+1:0] d_rd;
  logic [LAT_W+1:0] d_wr;
  logic [LAT_W+1:0] d_sel;
  logic [LAT_W-1:0] push_cnt;
  logic [TYP_W-1:0] push_type;

  always_comb begin
    d_rd  = {2'b00, CL}  + {2'b00, AL} - {2'b00, RD_PRE};
    d_wr  = {2'b00, CWL} + {2'b00, AL} - {2'b00, WR_PRE};
    d_sel = cas_req[0] ? d_rd : d_wr;
    if (d_sel[LAT_W+1] || (d_sel == '0)) begin
      push_cnt = '0;                                   // d < 1 clamps to 1
    end else if (d_sel[LAT_W]) begin
      push_cnt = {{(LAT_W-1){1'b1}}, 1'b0};            // d saturates at 2^LAT_W-1
    end else begin
      push_cnt = d_sel[LAT_W-1:0] - LAT_W'(1);
    end
  end

`ifdef CTRL_RW_AUTOPRE_EN
  assign push_type = cas_req;
`else
  // Autoprecharge variants collapse onto their plain type; only rd/wr is kept.
  logic unused_req_hi;
  assign push_type     = cas_req[0];
  assign unused_req_hi = cas_req[1];
`endif

  // ---------------------------------------------------------------------------
  // Release and push selection
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] zero_mask;
  logic [DEPTH-1:0] rel_mask;
  logic [DEPTH-1:0] free_mask;
  logic [DEPTH-1:0] push_mask;
  logic [DEPTH-1:0] vld_next;
  logic             rel_any;
  logic             multi_zero;
  logic             push_any;
  logic             push_ok;
  logic [TYP_W-1:0] rel_type;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      zero_mask[i] = slot_vld[i] && (slot_cnt[i] == '0);
    end
  end

  // x & -x isolates the lowest set bit: lowest-index due slot wins the release.
  assign rel_mask   = zero_mask & (~zero_mask + DEPTH'(1));
  assign rel_any    = |zero_mask;
  assign multi_zero = |(zero_mask & ~rel_mask);

  // A slot releasing this edge counts as free, so a push into a full table
  // on a release edge is still accepted.
  assign free_mask = ~slot_vld | rel_mask;
  assign push_mask = free_mask & (~free_mask + DEPTH'(1));
  assign push_any  = |free_mask;
  assign push_ok   = cas_rdy && push_any;
  assign vld_next  = (slot_vld & ~rel_mask) | (push_ok ? push_mask : '0);

  always_comb begin
    rel_type = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rel_mask[i]) begin
        rel_type = rel_type | slot_type[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe decode and burst tracking
  // ---------------------------------------------------------------------------
  logic             rd_set;
  logic             wr_set;
  logic             rda_set;
  logic             wra_set;
  logic [BST_W-1:0] burst_next;

`ifdef CTRL_RW_AUTOPRE_EN
  always_comb begin
    rd_set  = rel_any && (rel_type == 2'b01);
    wr_set  = rel_any && (rel_type == 2'b00);
    rda_set = rel_any && (rel_type == 2'b11);
    wra_set = rel_any && (rel_type == 2'b10);
  end
`else
  always_comb begin
    rd_set  = rel_any &&  rel_type[0];
    wr_set  = rel_any && !rel_type[0];
    rda_set = 1'b0;
    wra_set = 1'b0;
  end
`endif

  always_comb begin
    if (rel_any) begin
      burst_next = BST_LEN;
    end else if (burst_cnt != '0) begin
      burst_next = burst_cnt - BST_W'(1);
    end else begin
      burst_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      slot_vld  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_cnt[i]  <= '0;
        slot_type[i] <= '0;
      end
      burst_cnt <= '0;
      rd_rdy    <= 1'b0;
      wr_rdy    <= 1'b0;
      rda_rdy   <= 1'b0;
      wra_rdy   <= 1'b0;
      rw_done   <= 1'b0;
      data_idle <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      slot_vld <= vld_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && push_mask[i]) begin
          slot_cnt[i]  <= push_cnt;
          slot_type[i] <= push_type;
        end else if (slot_vld[i] && (slot_cnt[i] != '0)) begin
          slot_cnt[i]  <= slot_cnt[i] - LAT_W'(1);
        end
      end
      burst_cnt <= burst_next;
      rd_rdy    <= rd_set;
      wr_rdy    <= wr_set;
      rda_rdy   <= rda_set;
      wra_rdy   <= wra_set;
      rw_done   <= (burst_next == BST_W'(1));
      // Occupancy is taken from before this edge (a fresh push shows up one
      // edge later), while the burst is taken after this edge so idle rises
      // on the edge the final burst clock ends.
      data_idle <= (slot_vld == '0) && (burst_next == '0);
      full      <= &vld_next;
      overflow  <= overflow | (cas_rdy && !push_any);
      // Either a second slot came due alongside the released one, or a new
      // burst is cut in before the running one reached its last clock.
      collision <= collision | multi_zero | (rel_any && (burst_cnt > BST_W'(1)));
    end
  end

  // At most one data-phase strobe may be active in any cycle.
  strobe_onehot: assert property (@(posedge CK_t) disable iff (reset)
    $onehot0({rd_rdy, wr_rdy, rda_rdy, wra_rdy}));

endmodule

// File: tb/tb_ctrl_rw_sched.sv
// Bench for ctrl_rw_sched: directed spec scenarios plus randomized traffic,
// all checked cycle by cycle against a due-time reference model.
module tb_ctrl_rw_sched;

  localparam int DEPTH = 4;
  localparam int LAT_W = 6;
  localparam int BL    = 8;
  localparam int HALF  = BL / 2;
  localparam int DMAX  = (1 << LAT_W) - 1;

  logic             CK_t    = 1'b0;
  logic             reset   = 1'b0;
  logic             cas_rdy = 1'b0;
  logic [1:0]       cas_req = 2'b00;
  logic [LAT_W-1:0] CL      = 6'd11;
  logic [LAT_W-1:0] CWL     = 6'd9;
  logic [LAT_W-1:0] AL      = 6'd0;
  logic [LAT_W-1:0] RD_PRE  = 6'd1;
  logic [LAT_W-1:0] WR_PRE  = 6'd1;
  logic rd_rdy, wr_rdy, rda_rdy, wra_rdy, rw_done, data_idle, full, overflow, collision;
  logic [8:0] outs;

  always #5 CK_t = ~CK_t;

  ctrl_rw_sched #(.DEPTH(DEPTH), .LAT_W(LAT_W), .BL(BL)) dut (
    .CK_t(CK_t), .reset(reset), .cas_rdy(cas_rdy), .cas_req(cas_req),
    .CL(CL), .CWL(CWL), .AL(AL), .RD_PRE(RD_PRE), .WR_PRE(WR_PRE),
    .rd_rdy(rd_rdy), .wr_rdy(wr_rdy), .rda_rdy(rda_rdy), .wra_rdy(wra_rdy),
    .rw_done(rw_done), .data_idle(data_idle), .full(full),
    .overflow(overflow), .collision(collision)
  );

  assign outs = {rd_rdy, wr_rdy, rda_rdy, wra_rdy, rw_done, data_idle, full, overflow, collision};

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: absolute due edges per slot ----------------
  bit         m_vld [DEPTH];
  int         m_due [DEPTH];
  logic [1:0] m_typ [DEPTH];
  int         last_rel;
  bit         m_ovf, m_col;
  logic [8:0] m_out;
  int         edge_n;

  int rd_pulses, first_rd, first_wr, first_rda;

  function automatic int calc_delay(input logic [1:0] req);
    int d;
    if (req[0]) d = int'(CL) + int'(AL) - int'(RD_PRE);
    else        d = int'(CWL) + int'(AL) - int'(WR_PRE);
    if (d < 1)    d = 1;
    if (d > DMAX) d = DMAX;
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 0; m_due[i] = 0; m_typ[i] = 2'b00;
    end
    last_rel = -1000;
    m_ovf = 0; m_col = 0;
    edge_n = 0;
  endtask

  task automatic model_edge();
    int rel   = -1;
    int nelig = 0;
    int cnt   = 0;
    int slot  = -1;
    bit pre_any = 0;
    bit srd = 0, swr = 0, srda = 0, swra = 0;
    bit done, idle;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_vld[i]) begin
        pre_any = 1;
        if (m_due[i] <= edge_n) begin
          nelig++;
          if (rel < 0) rel = i;
        end
      end
    end
    if (nelig > 1) m_col = 1;
    if (rel >= 0) begin
      // previous burst still has more than its final clock left
      if (last_rel + HALF - (edge_n - 1) > 1) m_col = 1;
      last_rel   = edge_n;
      m_vld[rel] = 0;
`ifdef CTRL_RW_AUTOPRE_EN
      case (m_typ[rel])
        2'b00:   swr  = 1;
        2'b01:   srd  = 1;
        2'b10:   swra = 1;
        default: srda = 1;
      endcase
`else
      if (m_typ[rel][0]) srd = 1;
      else               swr = 1;
`endif
    end
    if (cas_rdy) begin
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_vld[i]) slot = i;
      if (slot < 0) m_ovf = 1;
      else begin
        m_vld[slot] = 1;
        m_due[slot] = edge_n + calc_delay(cas_req);
        m_typ[slot] = cas_req;
      end
    end
    for (int i = 0; i < DEPTH; i++) cnt += int'(m_vld[i]);
    done = (last_rel + HALF - edge_n) == 1;
    idle = !pre_any && ((last_rel + HALF - edge_n) <= 0);
    m_out = {srd, swr, srda, swra, done, idle, (cnt == DEPTH), m_ovf, m_col};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clr_track();
    rd_pulses = 0; first_rd = -1; first_wr = -1; first_rda = -1;
  endtask

  task automatic step(input bit cas, input logic [1:0] req);
    cas_rdy = cas;
    cas_req = req;
    @(posedge CK_t);
    edge_n++;
    model_edge();
    @(negedge CK_t);
    check($sformatf("outs@edge%0d", edge_n), {23'd0, outs}, {23'd0, m_out});
    if (rd_rdy) begin
      rd_pulses++;
      if (first_rd < 0) first_rd = edge_n;
    end
    if (wr_rdy && first_wr < 0)   first_wr  = edge_n;
    if (rda_rdy && first_rda < 0) first_rda = edge_n;
    cas_rdy = 1'b0;
  endtask

  task automatic do_reset();
    cas_rdy = 1'b0;
    reset   = 1'b1;
    #2;
    check("reset_outs", {23'd0, outs}, 32'h0000_0008);
    @(negedge CK_t);
    reset = 1'b0;
    model_reset();
    clr_track();
  endtask

  task automatic set_lat(input int cl, input int cwl, input int al, input int rp, input int wp);
    CL = LAT_W'(cl); CWL = LAT_W'(cwl); AL = LAT_W'(al); RD_PRE = LAT_W'(rp); WR_PRE = LAT_W'(wp);
  endtask

  initial begin
    #1;
    // S1: single RD, d=10
    do_reset();
    set_lat(11, 9, 0, 1, 1);
    for (int e = 1; e <= 30; e++) step(e == 10, 2'b01);
    check("s1_first_rd", first_rd, 20);
    check("s1_rd_count", rd_pulses, 1);

    // S2: back-to-back bursts, no overlap
    do_reset();
    for (int e = 1; e <= 35; e++) step(e == 10 || e == 14, 2'b01);
    check("s2_rd_count", rd_pulses, 2);
    check("s2_collision", collision, 0);

    // S3: RD and WR due on the same edge
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      if (e == 10)      step(1'b1, 2'b01);
      else if (e == 12) step(1'b1, 2'b00);
      else              step(1'b0, 2'b00);
    end
    check("s3_first_rd", first_rd, 20);
    check("s3_first_wr", first_wr, 21);
    check("s3_collision", collision, 1);

    // S4: fill all slots, drop the extra command
    do_reset();
    set_lat(40, 9, 0, 1, 1);
    for (int e = 1; e <= 60; e++) step(e <= 5, 2'b01);
    check("s4_rd_count", rd_pulses, 4);
    check("s4_overflow", overflow, 1);

    // S5: reset mid-flight kills the pending strobe
    do_reset();
    set_lat(11, 9, 0, 1, 1);
    for (int e = 1; e <= 14; e++) step(e == 10, 2'b01);
    do_reset();
    for (int e = 1; e <= 15; e++) step(1'b0, 2'b00);
    check("s5_rd_count", rd_pulses, 0);
    check("s5_data_idle", data_idle, 1);

    // S6: negative delay clamps to 1
    do_reset();
    set_lat(0, 0, 0, 1, 1);
    for (int e = 1; e <= 20; e++) step(e == 10, 2'b01);
    check("s6_first_rd", first_rd, 11);

    // S7: RDA
    do_reset();
    set_lat(11, 9, 0, 1, 1);
    for (int e = 1; e <= 30; e++) step(e == 10, 2'b11);
`ifdef CTRL_RW_AUTOPRE_EN
    check("s7_first_rda", first_rda, 20);
    check("s7_rd_count", rd_pulses, 0);
`else
    check("s7_first_rd", first_rd, 20);
    check("s7_rda_none", first_rda, -1);
`endif

    // S8: delay saturates at 2^LAT_W-1
    do_reset();
    set_lat(63, 9, 63, 0, 1);
    for (int e = 1; e <= 75; e++) step(e == 1, 2'b01);
    check("s8_first_rd", first_rd, 64);

    // Random traffic
    do_reset();
    set_lat(11, 9, 0, 1, 1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 7) == 0)
          set_lat($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
                  $urandom_range(0, 63), $urandom_range(0, 63));
        else
          set_lat($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 4),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
